// File: rtl/ad_pkg.sv
// Shared definitions for the multi-channel ADC alignment block:
// link FSM state encoding, default timing constants and the delay clamp helper.
package ad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } ad_state_t;

  localparam int LINK_LEN_DEF   = 16;
  localparam int SYNC_LEN_DEF   = 32;
  localparam int SETTLE_LEN_DEF = 64;
  localparam int LOSS_LEN_DEF   = 8;

  // Out-of-range delay requests saturate at the deepest available tap.
  function automatic int unsigned clamp_dly(input int unsigned d, input int unsigned max_dly);
    return (d >= max_dly) ? (max_dly - 1) : d;
  endfunction

endpackage

// File: rtl/ad_dly_line.sv
// Single-channel sample delay line: shift register with tap mux and
// synchronous clear. Tap 0 passes the current input straight through.
module ad_dly_line #(
  parameter int DW      = 16,
  parameter int MAX_DLY = 8,
  parameter int TAP_W   = $clog2(MAX_DLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic [DW-1:0]    din,
  input  logic [TAP_W-1:0] tap,
  output logic [DW-1:0]    dout
);

  // Only MAX_DLY-1 stored samples are needed; the live input is tap 0.
  logic [DW-1:0] sr [MAX_DLY-1];

  // Shift in a new sample on each enabled cycle; clear wipes stale history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_DLY-1; i++) sr[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < MAX_DLY-1; i++) sr[i] <= '0;
    end else if (shift_en) begin
      sr[0] <= din;
      for (int i = 1; i < MAX_DLY-1; i++) sr[i] <= sr[i-1];
    end
  end

  // Select the sample that arrived 'tap' valid samples ago.
  always_comb begin
    dout = din;
    for (int i = 0; i < MAX_DLY-1; i++) begin
      if (tap == TAP_W'(i+1)) dout = sr[i];
    end
  end

endmodule

// File: rtl/ad_multi_align.sv
// Multi-channel ADC data alignment: link-state FSM driving the ADC SYNC pulse,
// per-channel programmable sample delays and a jointly valid packed output.
// Optional ramp pattern checker on channel 0 enabled by macro AD_PATTERN_CHK_EN.
module ad_multi_align import ad_pkg::*; #(
  parameter int CH         = 4,
  parameter int DW         = 16,
  parameter int MAX_DLY    = 8,
  parameter int DLY_W      = $clog2(MAX_DLY),
  parameter int LINK_LEN   = LINK_LEN_DEF,
  parameter int SYNC_LEN   = SYNC_LEN_DEF,
  parameter int SETTLE_LEN = SETTLE_LEN_DEF,
  parameter int LOSS_LEN   = LOSS_LEN_DEF
) (
  input  logic                i_ad_gclk,
  input  logic                i_io_reset,
  input  logic [CH*DW-1:0]    i_din,
  input  logic                i_din_vl,
  input  logic [CH*DLY_W-1:0] i_dly,
  input  logic                i_resync,
  output logic                o_sync,
  output logic [CH*DW-1:0]    o_dout,
  output logic                o_dout_vl,
  output logic [1:0]          o_state,
  output logic [7:0]          o_sync_cnt,
  output logic [15:0]         o_err_cnt
);

  localparam int TAP_W = $clog2(MAX_DLY);

  if (SETTLE_LEN < MAX_DLY) begin : g_settle_chk
    $error("SETTLE_LEN must be at least MAX_DLY so the delay lines fill before RUN");
  end

  ad_state_t        state, state_nxt;
  logic [15:0]      cnt, loss_cnt;
  logic [7:0]       sync_cnt;
  logic             sync_r, dout_vl_r;
  logic [CH*DW-1:0] dout_r;
  logic [TAP_W-1:0] dly_lat [CH];
  logic [DW-1:0]    tap_out [CH];
  logic             active, sync_done, loss_hit, enter_sync, shift_en, out_en;

  assign active     = (state == ST_SETTLE) || (state == ST_RUN);
  assign sync_done  = (state == ST_SYNC) && (cnt == 16'(SYNC_LEN-1));
  assign loss_hit   = active && !i_din_vl && (loss_cnt == 16'(LOSS_LEN-1));
  assign enter_sync = (state != ST_SYNC) && (state_nxt == ST_SYNC);
  assign shift_en   = active && i_din_vl;
  assign out_en     = (state == ST_RUN) && (state_nxt == ST_RUN) && i_din_vl;

  // State register.
  always_ff @(posedge i_ad_gclk or posedge i_io_reset) begin
    if (i_io_reset) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic; link loss takes priority over a resync request.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (i_din_vl && cnt == 16'(LINK_LEN-1)) state_nxt = ST_SYNC;
      ST_SYNC:   if (sync_done) state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (loss_hit)      state_nxt = ST_IDLE;
        else if (i_resync) state_nxt = ST_SYNC;
        else if (i_din_vl && cnt == 16'(SETTLE_LEN-1)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (loss_hit)      state_nxt = ST_IDLE;
        else if (i_resync) state_nxt = ST_SYNC;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Per-state phase counter (link run, sync pulse length, settle samples).
  always_ff @(posedge i_ad_gclk or posedge i_io_reset) begin
    if (i_io_reset)              cnt <= '0;
    else if (state_nxt != state) cnt <= '0;
    else begin
      case (state)
        ST_IDLE:   cnt <= i_din_vl ? cnt + 16'd1 : '0;
        ST_SYNC:   cnt <= cnt + 16'd1;
        ST_SETTLE: if (i_din_vl) cnt <= cnt + 16'd1;
        default:   cnt <= '0;
      endcase
    end
  end

  // Consecutive invalid-cycle counter used for link-loss detection.
  always_ff @(posedge i_ad_gclk or posedge i_io_reset) begin
    if (i_io_reset)                                       loss_cnt <= '0;
    else if (active && state_nxt == state && !i_din_vl)   loss_cnt <= loss_cnt + 16'd1;
    else                                                  loss_cnt <= '0;
  end

  // Capture the requested delays as SYNC begins so later changes are inert.
  always_ff @(posedge i_ad_gclk or posedge i_io_reset) begin
    if (i_io_reset) begin
      for (int k = 0; k < CH; k++) dly_lat[k] <= '0;
    end else if (enter_sync) begin
      for (int k = 0; k < CH; k++)
        dly_lat[k] <= TAP_W'(clamp_dly(32'(i_dly[k*DLY_W +: DLY_W]), 32'(MAX_DLY)));
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    ad_dly_line #(.DW(DW), .MAX_DLY(MAX_DLY), .TAP_W(TAP_W)) u_dly (
      .clk     (i_ad_gclk),
      .rst     (i_io_reset),
      .clr     (sync_done),
      .shift_en(shift_en),
      .din     (i_din[k*DW +: DW]),
      .tap     (dly_lat[k]),
      .dout    (tap_out[k])
    );
  end

  // Registered SYNC pulse, aligned output word, and completed-sync counter.
  always_ff @(posedge i_ad_gclk or posedge i_io_reset) begin
    if (i_io_reset) begin
      sync_r    <= 1'b0;
      dout_vl_r <= 1'b0;
      dout_r    <= '0;
      sync_cnt  <= '0;
    end else begin
      sync_r    <= (state_nxt == ST_SYNC);
      dout_vl_r <= out_en;
      if (out_en) begin
        for (int k = 0; k < CH; k++) dout_r[k*DW +: DW] <= tap_out[k];
      end
      if (state == ST_SETTLE && state_nxt == ST_RUN) sync_cnt <= sync_cnt + 8'd1;
    end
  end

  assign o_sync     = sync_r;
  assign o_dout     = dout_r;
  assign o_dout_vl  = dout_vl_r;
  assign o_state    = state;
  assign o_sync_cnt = sync_cnt;

`ifdef AD_PATTERN_CHK_EN
  logic [DW-1:0] prev_s;
  logic          chk_arm;
  logic [15:0]   err_cnt;
  logic [DW-1:0] ch0;

  assign ch0 = dout_r[DW-1:0];

  // Ramp checker on channel 0; the first output after entering RUN only seeds it.
  always_ff @(posedge i_ad_gclk or posedge i_io_reset) begin
    if (i_io_reset) begin
      prev_s  <= '0;
      chk_arm <= 1'b0;
      err_cnt <= '0;
    end else if (state != ST_RUN) begin
      chk_arm <= 1'b0;
    end else if (dout_vl_r) begin
      prev_s  <= ch0;
      chk_arm <= 1'b1;
      if (chk_arm && ch0 != prev_s + DW'(1) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

  assign o_err_cnt = err_cnt;
`else
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_ad_multi_align.sv
// Directed self-checking bench for ad_multi_align (CH=4, DW=16, MAX_DLY=8).
// Delay fields are widened to 4 bits so an over-range request (9) can be driven.
module tb_ad_multi_align;

  logic        clk;
  logic        rst;
  logic [63:0] din;
  logic        din_vl;
  logic [15:0] dly;
  logic        resync;
  logic        o_sync;
  logic [63:0] o_dout;
  logic        o_dout_vl;
  logic [1:0]  o_state;
  logic [7:0]  o_sync_cnt;
  logic [15:0] o_err_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] ramp;
  logic [15:0] last_ramp;
  logic [15:0] last_v;
  int          eff [4];
  int          sync_cycles;
  logic [63:0] held;

  ad_multi_align #(.CH(4), .DW(16), .MAX_DLY(8), .DLY_W(4)) dut (
    .i_ad_gclk (clk),
    .i_io_reset(rst),
    .i_din     (din),
    .i_din_vl  (din_vl),
    .i_dly     (dly),
    .i_resync  (resync),
    .o_sync    (o_sync),
    .o_dout    (o_dout),
    .o_dout_vl (o_dout_vl),
    .o_state   (o_state),
    .o_sync_cnt(o_sync_cnt),
    .o_err_cnt (o_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs at a falling edge, then wait for the next falling edge.
  task automatic applyStimulus(input logic vl, input logic rs, input logic corrupt);
    din_vl = vl;
    resync = rs;
    if (vl) begin
      last_v    = corrupt ? 16'h00FF : ramp;
      din       = {4{last_v}};
      last_ramp = ramp;
      ramp      = ramp + 16'd1;
    end
    @(negedge clk);
  endtask

  function automatic int clampRef(input int d);
    return (d > 7) ? 7 : d;
  endfunction

  task automatic setDelays(input logic [15:0] d);
    dly = d;
    for (int k = 0; k < 4; k++) eff[k] = clampRef(int'(dly[4*k +: 4]));
  endtask

  // Each channel k should show the ramp sample eff[k] valid samples back.
  task automatic checkChannels(input string tag);
    logic [15:0] exp_v;
    for (int k = 0; k < 4; k++) begin
      exp_v = last_ramp - 16'(eff[k]);
      checkOutput($sformatf("%s_ch%0d", tag, k), 64'(o_dout[k*16 +: 16]), 64'(exp_v));
    end
  endtask

  // Feed valid samples until RUN is reached, with a bounded cycle budget.
  task automatic runToRun(input string tag);
    for (int i = 0; i < 300 && o_state != 2'd3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput(tag, 64'(o_state), 64'd3);
  endtask

  initial begin
    rst = 1'b1; din = '0; din_vl = 1'b0; resync = 1'b0;
    ramp = 16'h0100; last_ramp = '0; last_v = '0;
    setDelays(16'h3210);
    repeat (2) @(negedge clk);
    checkOutput("rst_state", 64'(o_state), 64'd0);
    checkOutput("rst_sync", 64'(o_sync), 64'd0);
    checkOutput("rst_dout", o_dout, 64'd0);
    checkOutput("rst_vl", 64'(o_dout_vl), 64'd0);
    checkOutput("rst_sync_cnt", 64'(o_sync_cnt), 64'd0);
    checkOutput("rst_err", 64'(o_err_cnt), 64'd0);
    rst = 1'b0;

    // Link-up after 16 consecutive valid cycles.
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("idle_before_link", 64'(o_state), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("link_up_state", 64'(o_state), 64'd1);
    checkOutput("sync_rise", 64'(o_sync), 64'd1);

    // SYNC pulse length, with a resync request inside SYNC that must be ignored.
    sync_cycles = 1;
    for (int i = 0; i < 40 && o_sync; i++) begin
      applyStimulus(1'b1, i == 5, 1'b0);
      if (o_sync) sync_cycles++;
    end
    checkOutput("sync_len", 64'(sync_cycles), 64'd32);
    checkOutput("settle_state", 64'(o_state), 64'd2);

    for (int i = 0; i < 63; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("settle_wait", 64'(o_state), 64'd2);
    checkOutput("settle_sync_cnt", 64'(o_sync_cnt), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("run_state", 64'(o_state), 64'd3);
    checkOutput("run_sync_cnt", 64'(o_sync_cnt), 64'd1);
    checkOutput("run_entry_vl", 64'(o_dout_vl), 64'd0);

    // Aligned output with delays {3,2,1,0}.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("run_vl", 64'(o_dout_vl), 64'd1);
      checkChannels("align");
    end

    // Seven invalid cycles then valid: link stays up, output holds meanwhile.
    held = o_dout;
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("gap7_state", 64'(o_state), 64'd3);
    checkOutput("gap7_vl", 64'(o_dout_vl), 64'd0);
    checkOutput("gap7_hold", o_dout, held);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("gap7_resume_vl", 64'(o_dout_vl), 64'd1);
    checkChannels("resume");

    // Eight invalid cycles: link loss back to IDLE.
    held = o_dout;
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("loss7_state", 64'(o_state), 64'd3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("loss_state", 64'(o_state), 64'd0);
    checkOutput("loss_vl", 64'(o_dout_vl), 64'd0);
    checkOutput("loss_hold", o_dout, held);

    // Over-range delay on channel 2 clamps to 7.
    setDelays(16'h3910);
    runToRun("reach_run_clamp");
    checkOutput("clamp_sync_cnt", 64'(o_sync_cnt), 64'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkChannels("clamp");
    end

    // Resync coinciding with the eighth invalid cycle: loss wins.
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("loss_vs_resync", 64'(o_state), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("resync_idle_ignored", 64'(o_state), 64'd0);

    runToRun("reach_run_again");
    checkOutput("again_sync_cnt", 64'(o_sync_cnt), 64'd3);

    // Resync alone in RUN.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("resync_state", 64'(o_state), 64'd1);
    checkOutput("resync_vl", 64'(o_dout_vl), 64'd0);
    checkOutput("resync_sync", 64'(o_sync), 64'd1);
    runToRun("reach_run_resync");
    checkOutput("resync_sync_cnt", 64'(o_sync_cnt), 64'd4);

    // Ramp restarted at RUN entry, with sample 0x0010 replaced by 0x00FF.
    checkOutput("err_before", 64'(o_err_cnt), 64'd0);
    ramp = 16'h0000;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 1'b0, ramp == 16'h0010);
      if (last_ramp == 16'h0010) checkOutput("corrupt_ch0", 64'(o_dout[15:0]), 64'h00FF);
    end
`ifdef AD_PATTERN_CHK_EN
    checkOutput("err_cnt", 64'(o_err_cnt), 64'd2);
`else
    checkOutput("err_cnt", 64'(o_err_cnt), 64'd0);
`endif

    // Reset in the middle of a SYNC pulse.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("pre_rst_sync", 64'(o_sync), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_sync", 64'(o_sync), 64'd0);
    checkOutput("midrst_state", 64'(o_state), 64'd0);
    checkOutput("midrst_sync_cnt", 64'(o_sync_cnt), 64'd0);
    checkOutput("midrst_dout", o_dout, 64'd0);
    checkOutput("midrst_err", 64'(o_err_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
